// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer.
// Owns the 16-bit PC. It keeps at most one instruction-memory read
// outstanding and holds one fetched instruction for decode. It honours
// decode stalls, redirects on taken branches, and parks when HLT is fetched.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   stall        decode cannot accept the buffered instruction this cycle
//   br_taken     taken branch from execute; flush and redirect
//   br_target    redirect address (bit 0 forced to 0)
//   imem_req     single-cycle read request pulse (combinational)
//   imem_addr    read address, valid while imem_req=1
//   imem_ready   read data valid this cycle
//   imem_rdata   returned instruction word
//   instr        buffered instruction to decode
//   instr_pc     address the buffered instruction was fetched from
//   instr_valid  buffer holds an instruction
//   pc           next fetch address
//   halted       HLT fetched; fetch parked
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  output logic [15:0] pc,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      state;
  logic        consume;
  logic        is_hlt;
  logic [15:0] target;

  assign consume   = instr_valid & ~stall;
  assign is_hlt    = (imem_rdata[15:12] == HALT_OPCODE);
  assign target    = br_target & 16'hFFFE;
  // The request may only issue when the buffer is empty or is drained this
  // same cycle. That way a returning read can never overwrite a live instruction.
  assign imem_req  = ~rst & (state == S_ISSUE) & ~br_taken & (~instr_valid | ~stall);
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_ISSUE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      // Consumption clears the buffer. A refill or flush later in this block
      // takes precedence.
      if (consume) instr_valid <= 1'b0;

      case (state)
        S_ISSUE: begin
          if (br_taken) begin
            pc          <= target;
            instr_valid <= 1'b0;
          end else if (imem_req) begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (br_taken) begin
            pc          <= target;
            instr_valid <= 1'b0;
            // If the read is still in flight, its late response must be absorbed.
            state       <= imem_ready ? S_ISSUE : S_DRAIN;
          end else if (imem_ready) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            if (is_hlt) begin
              halted <= 1'b1;
              state  <= S_HALT;
            end else begin
              pc    <= pc + 16'd2;
              state <= S_ISSUE;
            end
          end
        end

        S_DRAIN: begin
          if (br_taken) begin
            pc          <= target;
            instr_valid <= 1'b0;
          end
          if (imem_ready) state <= S_ISSUE;
        end

        S_HALT: begin
          if (br_taken) begin
            halted      <= 1'b0;
            pc          <= target;
            instr_valid <= 1'b0;
            state       <= S_ISSUE;
          end
        end

        default: state <= S_ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_target = '0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic [15:0] pc;
  logic        halted;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_req[$];
  logic [31:0] exp_instr[$];
  logic        prev_valid = 1'b0;

  fetch_ctrl #(.RESET_PC(16'h0000), .HALT_OPCODE(4'hF)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endfunction

  // Scoreboard monitor: request addresses and newly filled buffers are
  // compared against expectations queued by the stimulus.
  always @(negedge clk) begin
    #2;
    if (imem_req === 1'b1) begin
      if (exp_req.size() == 0) chk("unexpected_req", {16'h0, imem_addr}, 32'hDEAD_DEAD);
      else chk("req_addr", {16'h0, imem_addr}, {16'h0, exp_req.pop_front()});
    end
    if (instr_valid === 1'b1 && !prev_valid) begin
      if (exp_instr.size() == 0) chk("unexpected_fill", {instr_pc, instr}, 32'hDEAD_DEAD);
      else chk("fill_pc_instr", {instr_pc, instr}, exp_instr.pop_front());
    end
    prev_valid = (instr_valid === 1'b1);
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset
    step(); rst = 1'b1;
    step(); #1;
    chk("rst_pc", {16'h0, pc}, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_instr", {instr_pc, instr}, 32'h0);
    chk("rst_req", {31'h0, imem_req}, 32'h0);

    // Two fetches with 1-cycle latency
    step(); rst = 1'b0; exp_req.push_back(16'h0000); #1;
    chk("req0", {31'h0, imem_req}, 32'h1);
    step(); imem_ready = 1'b1; imem_rdata = 16'h1234; exp_instr.push_back({16'h0000, 16'h1234}); #1;
    chk("wait_no_req", {31'h0, imem_req}, 32'h0);
    step(); imem_ready = 1'b0; exp_req.push_back(16'h0002); #1;
    chk("f1_valid", {31'h0, instr_valid}, 32'h1);
    chk("f1_instr", {instr_pc, instr}, {16'h0000, 16'h1234});
    chk("f1_pc", {16'h0, pc}, 32'h0002);
    step(); imem_ready = 1'b1; imem_rdata = 16'h2345; exp_instr.push_back({16'h0002, 16'h2345});

    // Stall holds the buffer and blocks requests
    step(); imem_ready = 1'b0; stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      #1;
      chk("stall_req", {31'h0, imem_req}, 32'h0);
      chk("stall_instr", {instr_pc, instr}, {16'h0002, 16'h2345});
      chk("stall_pc", {16'h0, pc}, 32'h0004);
    end
    step(); stall = 1'b0; exp_req.push_back(16'h0004); #1;
    chk("unstall_req", {31'h0, imem_req}, 32'h1);

    // Latency 4 with a branch in the second WAIT cycle
    step();
    step(); br_taken = 1'b1; br_target = 16'h0101;
    step(); br_taken = 1'b0; #1;
    chk("drain_pc", {16'h0, pc}, 32'h0100);
    chk("drain_valid", {31'h0, instr_valid}, 32'h0);
    chk("drain_req", {31'h0, imem_req}, 32'h0);
    step(); imem_ready = 1'b1; imem_rdata = 16'hAAAA;
    step(); imem_ready = 1'b0; exp_req.push_back(16'h0100); #1;
    chk("post_drain_valid", {31'h0, instr_valid}, 32'h0);
    chk("post_drain_req", {31'h0, imem_req}, 32'h1);

    // Response coinciding with a branch is discarded
    step(); imem_ready = 1'b1; imem_rdata = 16'hBBBB; br_taken = 1'b1; br_target = 16'h0040;
    step(); imem_ready = 1'b0; br_taken = 1'b0; exp_req.push_back(16'h0040); #1;
    chk("redir_pc", {16'h0, pc}, 32'h0040);
    chk("redir_valid", {31'h0, instr_valid}, 32'h0);

    // HLT fetch parks the PC
    step(); imem_ready = 1'b1; imem_rdata = 16'hF000; exp_instr.push_back({16'h0040, 16'hF000});
    step(); imem_ready = 1'b0; #1;
    chk("hlt_halted", {31'h0, halted}, 32'h1);
    chk("hlt_instr", {instr_pc, instr}, {16'h0040, 16'hF000});
    for (int i = 0; i < 10; i++) begin
      step(); imem_ready = (i == 3); #1;
      chk("hlt_pc", {16'h0, pc}, 32'h0040);
      chk("hlt_req", {31'h0, imem_req}, 32'h0);
    end
    step(); imem_ready = 1'b0; br_taken = 1'b1; br_target = 16'h0080; #1;
    chk("hlt_br_req", {31'h0, imem_req}, 32'h0);
    step(); br_taken = 1'b0; exp_req.push_back(16'h0080); #1;
    chk("unhalt", {31'h0, halted}, 32'h0);
    chk("unhalt_pc", {16'h0, pc}, 32'h0080);

    // PC wrap at 0xFFFE
    step(); imem_ready = 1'b1; br_taken = 1'b1; br_target = 16'hFFFE;
    step(); imem_ready = 1'b0; br_taken = 1'b0; exp_req.push_back(16'hFFFE);
    step(); imem_ready = 1'b1; imem_rdata = 16'h5678; exp_instr.push_back({16'hFFFE, 16'h5678});
    step(); imem_ready = 1'b0; exp_req.push_back(16'h0000); #1;
    chk("wrap_pc", {16'h0, pc}, 32'h0000);
    chk("wrap_instr", {instr_pc, instr}, {16'hFFFE, 16'h5678});

    // Reset during WAIT; the late response must be ignored
    step(); rst = 1'b1;
    step(); rst = 1'b0; imem_ready = 1'b1; imem_rdata = 16'h9999; exp_req.push_back(16'h0000); #1;
    chk("rst2_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst2_req", {31'h0, imem_req}, 32'h1);
    step(); imem_ready = 1'b0; #1;
    chk("rst2_ignored", {15'h0, instr_valid, instr}, 32'h0);
    step(); imem_ready = 1'b1; imem_rdata = 16'h1111; exp_instr.push_back({16'h0000, 16'h1111});
    step(); imem_ready = 1'b0; stall = 1'b1; #1;
    chk("rst2_fill_pc", {16'h0, pc}, 32'h0002);
    step(); step(); #3;

    chk("req_queue_empty", exp_req.size(), 32'd0);
    chk("instr_queue_empty", exp_instr.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
